mem_access_unit: RTL and testbench

- Load/store sequencer directly upstream of the word-addressed data memory (32 x 32-bit, MemWrite/MemRead, word index address).
- Accepts byte, halfword and word loads and stores from the execute stage.
- Converts them into word-only memory transactions:
  - sub-word stores become read-modify-write sequences;
  - loads are lane-extracted with sign or zero extension.
- Returns load data to writeback with a done pulse and holds the core via ready.

---
 rtl/mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a word-addressed data memory.
// Byte/halfword/word loads are lane-extracted with sign or zero extension.
// Sub-word stores are performed as read-modify-write sequences.
// Optional feature macro: MEM_ALIGN_TRAP_EN
//   defined   : misaligned halfword/word requests are rejected with misaligned+done
//   undefined : misaligned is tied 0 and offending low address bits are cleared

module mem_access_unit #(
   parameter int ADDR_W   = 5,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [1:0]        size,
   input  logic              ld_unsigned,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misaligned,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Last WAIT count value: the cycle on which mem_rdata is valid.
   localparam logic [1:0] CNT_LAST = 2'(READ_LAT - 1);

   // Pick the addressed lane out of a read word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                input logic [1:0]  lo,
                                                input logic [1:0]  sz,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lo[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Replace only the addressed byte/half of the read word with the store data.
   function automatic logic [31:0] store_merge(input logic [31:0] w,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  sz,
                                               input logic [15:0] d);
      logic [31:0] r;
      r = w;
      case (sz)
         2'b00: begin
            case (lo)
               2'd0:    r[7:0]   = d[7:0];
               2'd1:    r[15:8]  = d[7:0];
               2'd2:    r[23:16] = d[7:0];
               default: r[31:24] = d[7:0];
            endcase
         end
         2'b01: begin
            if (lo[1]) begin
               r[31:16] = d;
            end else begin
               r[15:0] = d;
            end
         end
         default: r = w;
      endcase
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic                store_q, store_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                we_q, we_d;
   logic                re_q, re_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                accept_s;
   logic                mis_s;
   logic [ADDR_W+1:0]   addr_al_s;
   logic                unused_s;

   assign accept_s = (state_q == ST_IDLE) && req_valid && (MemRead || MemWrite);

   // Alignment check and low-bit clearing of the incoming byte address.
   always_comb begin
      addr_al_s = addr[ADDR_W+1:0];
      mis_s     = 1'b0;
      case (size)
         2'b00: begin
            mis_s = 1'b0;
         end
         2'b01: begin
            if (addr[0]) begin
               mis_s        = 1'b1;
               addr_al_s[0] = 1'b0;
            end else begin
               mis_s = 1'b0;
            end
         end
         default: begin
            if (addr[1:0] != 2'b00) begin
               mis_s          = 1'b1;
               addr_al_s[1:0] = 2'b00;
            end else begin
               mis_s = 1'b0;
            end
         end
      endcase
   end

`ifdef MEM_ALIGN_TRAP_EN
   logic mis_q, mis_d;
   assign misaligned = mis_q;
   assign unused_s   = ^addr[31:ADDR_W+2];
`else
   assign misaligned = 1'b0;
   assign unused_s   = ^{addr[31:ADDR_W+2], mis_s};
`endif

   // Next-state, request capture, lane merge/extract and output decode.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      uns_d       = uns_q;
      store_d     = store_q;
      cnt_d       = cnt_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
`ifdef MEM_ALIGN_TRAP_EN
      mis_d       = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               addr_d  = addr_al_s;
               wdata_d = wdata[15:0];
               size_d  = size;
               uns_d   = ld_unsigned;
               store_d = MemWrite;
`ifdef MEM_ALIGN_TRAP_EN
               if (mis_s) begin
                  mis_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (MemWrite && size[1]) begin
                  mem_wdata_d = wdata;
                  state_d     = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
`else
               if (MemWrite && size[1]) begin
                  mem_wdata_d = wdata;
                  state_d     = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            cnt_d   = 2'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               if (store_q) begin
                  mem_wdata_d = store_merge(mem_rdata, addr_q[1:0], size_q, wdata_q);
                  state_d     = ST_WR;
               end else begin
                  rdata_d = load_extract(mem_rdata, addr_q[1:0], size_q, uns_q);
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ST_WR: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
      re_d    = (state_d == ST_RD);
      we_d    = (state_d == ST_WR);
      done_d  = (state_d == ST_DONE);
   end

   // State, captured request and registered outputs; reset discards any request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= 16'h0000;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         store_q     <= 1'b0;
         cnt_q       <= 2'd0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         mem_wdata_q <= 32'h0000_0000;
         rdata_q     <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         store_q     <= store_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         we_q        <= we_d;
         re_q        <= re_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef MEM_ALIGN_TRAP_EN
   // Alignment fault pulse register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end
`endif

   assign ready     = ready_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign mem_we    = we_q;
   assign mem_re    = re_q;
   assign mem_addr  = addr_q[ADDR_W+1:2];
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a 32 x 32-bit word memory model
// (READ_LAT = 1). Expected values are hand-computed constants.

module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  size;
   logic        ld_unsigned;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic [31:0] rdata;
   logic        misaligned;
   logic        mem_we;
   logic        mem_re;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:31];
   int          we_cnt = 0;
   int          re_cnt = 0;
   logic [4:0]  last_we_addr = 5'd0;
   logic [31:0] last_we_data = 32'h0;
   logic [4:0]  last_re_addr = 5'd0;

   int checks   = 0;
   int failures = 0;

   mem_access_unit #(.ADDR_W(5), .READ_LAT(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .size       (size),
      .ld_unsigned(ld_unsigned),
      .addr       (addr),
      .wdata      (wdata),
      .ready      (ready),
      .done       (done),
      .rdata      (rdata),
      .misaligned (misaligned),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Word memory with one-cycle read latency, plus access monitors.
   always @(posedge clk) begin
      if (mem_re) begin
         mem_rdata    <= mem[mem_addr];
         re_cnt       <= re_cnt + 1;
         last_re_addr <= mem_addr;
      end
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt        <= we_cnt + 1;
         last_we_addr  <= mem_addr;
         last_we_data  <= mem_wdata;
      end
   end

   // Issue one request, return cycles from accept to done, then step into IDLE.
   task automatic do_req(input logic mr, input logic mw, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic mis_seen);
      req_valid = 1'b1; MemRead = mr; MemWrite = mw; size = sz;
      ld_unsigned = uns; addr = a; wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      mis_seen = misaligned;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      size = 2'b00; ld_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if ({done, misaligned, mem_we, mem_re} !== 4'b0000) begin failures++; $display("FAIL reset_strobes: got %b expected 0000", {done, misaligned, mem_we, mem_re}); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if ({mem_addr, mem_wdata} !== 37'h0) begin failures++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word_store_load();
      int lat; logic mis; int we0; int re0;
      we0 = we_cnt; re0 = re_cnt;
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, lat, mis);
      checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency: got %0d expected 2", lat); end
      checks++; if (we_cnt - we0 !== 1 || re_cnt !== re0) begin failures++; $display("FAIL sw_access_count: got we=%0d re=%0d expected 1/0", we_cnt - we0, re_cnt - re0); end
      checks++; if (last_we_addr !== 5'd2 || last_we_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_bus: got %0d/%h expected 2/deadbeef", last_we_addr, last_we_data); end
      re0 = re_cnt;
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, mis);
      checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency: got %0d expected 3", lat); end
      checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata: got %h expected deadbeef", rdata); end
      checks++; if (re_cnt - re0 !== 1 || last_re_addr !== 5'd2) begin failures++; $display("FAIL lw_read: got n=%0d addr=%0d expected 1/2", re_cnt - re0, last_re_addr); end
   endtask

   task automatic test_byte_rmw();
      int lat; logic mis; int we0; int re0;
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, lat, mis);
      we0 = we_cnt; re0 = re_cnt;
      do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AA, lat, mis);
      checks++; if (lat !== 4) begin failures++; $display("FAIL sb_latency: got %0d expected 4", lat); end
      checks++; if (we_cnt - we0 !== 1 || re_cnt - re0 !== 1) begin failures++; $display("FAIL sb_access_count: got we=%0d re=%0d expected 1/1", we_cnt - we0, re_cnt - re0); end
      checks++; if (last_we_data !== 32'h1122AA44 || mem[2] !== 32'h1122AA44) begin failures++; $display("FAIL sb_merge: got %h mem=%h expected 1122aa44", last_we_data, mem[2]); end
      checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sb_rdata_hold: got %h expected deadbeef", rdata); end
      do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h0A, 32'hCAFE5678, lat, mis);
      checks++; if (mem[2] !== 32'h5678AA44) begin failures++; $display("FAIL sh_merge: got %h expected 5678aa44", mem[2]); end
   endtask

   task automatic test_load_ext();
      int lat; logic mis;
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF7F01, lat, mis);
      do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, lat, mis);
      checks++; if (rdata !== 32'hFFFFFFFF || lat !== 3) begin failures++; $display("FAIL lb: got %h lat=%0d expected ffffffff lat=3", rdata, lat); end
      do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h0A, 32'h0, lat, mis);
      checks++; if (rdata !== 32'h000000FF) begin failures++; $display("FAIL lbu: got %h expected 000000ff", rdata); end
      do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, lat, mis);
      checks++; if (rdata !== 32'hFFFF80FF) begin failures++; $display("FAIL lh: got %h expected ffff80ff", rdata); end
      do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, lat, mis);
      checks++; if (rdata !== 32'h00007F01) begin failures++; $display("FAIL lhu: got %h expected 00007f01", rdata); end
      do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, lat, mis);
      checks++; if (rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_lane3: got %h expected ffffff80", rdata); end
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h88, 32'h0, lat, mis);
      checks++; if (rdata !== 32'h80FF7F01 || last_re_addr !== 5'd2) begin failures++; $display("FAIL lw_wrap: got %h addr=%0d expected 80ff7f01/2", rdata, last_re_addr); end
   endtask

   task automatic test_busy_priority();
      int lat; logic mis; int we0; int re0;
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'h00000000, lat, mis);
      we0 = we_cnt;
      req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; size = 2'b10; addr = 32'h08;
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h0C; wdata = 32'h00000099;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready_low: got %b expected 0", ready); end
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat !== 3 || ready !== 1'b0) begin failures++; $display("FAIL busy_load_done: got lat=%0d ready=%b expected 3/0", lat, ready); end
      req_valid = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL busy_ready_back: got %b expected 1", ready); end
      checks++; if (we_cnt !== we0 || mem[3] !== 32'h0 || rdata !== 32'h80FF7F01) begin failures++; $display("FAIL busy_ignored: got we=%0d mem3=%h rdata=%h expected 0/0/80ff7f01", we_cnt - we0, mem[3], rdata); end
      // strobe with neither operation must be ignored
      re0 = re_cnt;
      req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1 || re_cnt !== re0 || we_cnt !== we0) begin failures++; $display("FAIL noop_ignored: got ready=%b re=%0d we=%0d expected 1/0/0", ready, re_cnt - re0, we_cnt - we0); end
      do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0C, 32'h12345678, lat, mis);
      checks++; if (lat !== 2 || re_cnt !== re0 || we_cnt - we0 !== 1) begin failures++; $display("FAIL dual_op_store: got lat=%0d re=%0d we=%0d expected 2/0/1", lat, re_cnt - re0, we_cnt - we0); end
      checks++; if (mem[3] !== 32'h12345678 || rdata !== 32'h80FF7F01) begin failures++; $display("FAIL dual_op_data: got mem3=%h rdata=%h expected 12345678/80ff7f01", mem[3], rdata); end
   endtask

   task automatic test_reset_mid_rmw();
      int lat; logic mis; int we0;
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, lat, mis);
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, mis);
      we0 = we_cnt;
      req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; size = 2'b00;
      addr = 32'h09; wdata = 32'h000000AA;
      @(posedge clk); #1;
      req_valid = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (ready !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_outputs: got ready=%b rdata=%h expected 1/0", ready, rdata); end
      checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL rst_mid_strobes: got we=%b re=%b expected 0/0", mem_we, mem_re); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (we_cnt !== we0 || mem[2] !== 32'h11223344) begin failures++; $display("FAIL rst_mid_no_write: got we=%0d mem2=%h expected 0/11223344", we_cnt - we0, mem[2]); end
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, mis);
      checks++; if (rdata !== 32'h11223344) begin failures++; $display("FAIL rst_mid_recover: got %h expected 11223344", rdata); end
   endtask

   task automatic test_align();
      int lat; logic mis; int re0;
      re0 = re_cnt;
`ifdef MEM_ALIGN_TRAP_EN
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0A, 32'h0, lat, mis);
      checks++; if (lat !== 1 || mis !== 1'b1) begin failures++; $display("FAIL trap_pulse: got lat=%0d mis=%b expected 1/1", lat, mis); end
      checks++; if (re_cnt !== re0 || rdata !== 32'h11223344) begin failures++; $display("FAIL trap_no_access: got re=%0d rdata=%h expected 0/11223344", re_cnt - re0, rdata); end
      checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL trap_one_cycle: got %b expected 0", misaligned); end
`else
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0E, 32'h5A5A0F0F, lat, mis);
      checks++; if (last_we_addr !== 5'd3 || mem[3] !== 32'h5A5A0F0F) begin failures++; $display("FAIL align_sw_force: got %0d/%h expected 3/5a5a0f0f", last_we_addr, mem[3]); end
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0F, 32'h0, lat, mis);
      checks++; if (rdata !== 32'h5A5A0F0F || last_re_addr !== 5'd3) begin failures++; $display("FAIL align_lw_word3: got %h addr=%0d expected 5a5a0f0f/3", rdata, last_re_addr); end
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0A, 32'h0, lat, mis);
      checks++; if (lat !== 3 || mis !== 1'b0 || last_re_addr !== 5'd2) begin failures++; $display("FAIL align_lw: got lat=%0d mis=%b addr=%0d expected 3/0/2", lat, mis, last_re_addr); end
      checks++; if (rdata !== 32'h11223344) begin failures++; $display("FAIL align_lw_data: got %h expected 11223344", rdata); end
      do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h0B, 32'h0, lat, mis);
      checks++; if (rdata !== 32'h00001122) begin failures++; $display("FAIL align_lh: got %h expected 00001122", rdata); end
`endif
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_byte_rmw();
      test_load_ext();
      test_busy_priority();
      test_reset_mid_rmw();
      test_align();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
